// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants, divisor type and sanitising helper for clk_enable_divider
//
// Purpose : common definitions for the clock-enable divider slice.
// Contents: CLK_DIV_CNT_W   - default counter/divisor width
//           CLK_DIV_DEFAULT - divisor loaded by reset (1 Hz tick at 50 MHz)
//           div_t           - divisor/counter type at the default width
//           div_sanitize    - maps a divisor of 0 onto 1
// Options : none here; the step feature is selected by CLK_DIV_STEP_EN in the interface and top.

package clk_div_pkg;

   localparam int CLK_DIV_CNT_W   = 32;
   localparam int CLK_DIV_DEFAULT = 50_000_000;

   typedef logic [CLK_DIV_CNT_W-1:0] div_t;

   // 0 and 1 both mean "tick every cycle"; folding 0 onto 1 keeps N-1 from underflowing.
   function automatic div_t div_sanitize(input div_t d);
      return (d == '0) ? div_t'(1) : d;
   endfunction

endpackage

// File: rtl/clk_enable_divider_if.sv
// rtl/clk_enable_divider_if.sv - control/status bundle between a controller and clk_enable_divider
//
// Purpose : groups the run/load controls and tick/status outputs of the divider.
// Signals : run, div_load, div_val      controller -> divider
//           step_mode, step_req         controller -> divider (only with CLK_DIV_STEP_EN)
//           div_busy, tick, slow_out, cnt   divider -> controller
// Modports: master (controller side), slave (divider side).
// Options : CLK_DIV_STEP_EN adds the step_mode/step_req signals.

interface clk_enable_divider_if #(
   parameter int CNT_W = clk_div_pkg::CLK_DIV_CNT_W
) ();

   logic             run;
   logic             div_load;
   logic [CNT_W-1:0] div_val;
   logic             div_busy;
   logic             tick;
   logic             slow_out;
   logic [CNT_W-1:0] cnt;
`ifdef CLK_DIV_STEP_EN
   logic             step_mode;
   logic             step_req;

   modport master (
      output run, div_load, div_val, step_mode, step_req,
      input  div_busy, tick, slow_out, cnt
   );

   modport slave (
      input  run, div_load, div_val, step_mode, step_req,
      output div_busy, tick, slow_out, cnt
   );
`else
   modport master (
      output run, div_load, div_val,
      input  div_busy, tick, slow_out, cnt
   );

   modport slave (
      input  run, div_load, div_val,
      output div_busy, tick, slow_out, cnt
   );
`endif

endinterface

// File: rtl/step_edge_detect.sv
// rtl/step_edge_detect.sv - registered rising-edge detector for the manual step request
//
// Purpose : produces a one-cycle pulse, one cycle after i_d goes 0->1.
// Ports   : clk     system clock
//           rst     synchronous active-high reset
//           i_d     level input (step request)
//           o_rise  registered one-cycle rise pulse
// Options : compiled only with CLK_DIV_STEP_EN.

`ifdef CLK_DIV_STEP_EN
module step_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_rise
);

   logic r_prev;
   logic r_rise;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_prev <= 1'b0;
         r_rise <= 1'b0;
      end else begin
         r_prev <= i_d;
         r_rise <= i_d & ~r_prev;
      end
   end

   assign o_rise = r_rise;

endmodule
`endif

// File: rtl/clk_enable_divider.sv
// rtl/clk_enable_divider.sv - runtime-programmable clock-enable generator (tick every N cycles)
//
// Purpose : counts clk cycles 0..N-1 and emits a registered one-cycle tick on each wrap plus
//           a slow_out square wave that toggles with every tick. N is reloaded glitch-free at
//           the next wrap; clk itself is never divided.
// Params  : CNT_W       counter/divisor width (at most clk_div_pkg::CLK_DIV_CNT_W)
//           DEFAULT_DIV divisor after reset
// Ports   : clk   system clock
//           rst   synchronous active-high reset
//           bus   clk_enable_divider_if.slave: run, div_load, div_val, [step_mode, step_req]
//                 in; div_busy, tick, slow_out, cnt out
// Options : CLK_DIV_STEP_EN enables the manual single-step mode.

module clk_enable_divider
   import clk_div_pkg::*;
#(
   parameter int CNT_W       = CLK_DIV_CNT_W,
   parameter int DEFAULT_DIV = CLK_DIV_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   clk_enable_divider_if.slave  bus
);

   localparam logic [CNT_W-1:0] RESET_DIV = CNT_W'(div_sanitize(div_t'(DEFAULT_DIV)));

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_div;
   logic [CNT_W-1:0] r_pend;
   logic             r_busy;
   logic             r_tick;
   logic             r_slow;

   logic             w_freeze;
   logic             w_step;
   logic             w_wrap;
   logic [CNT_W-1:0] w_last;
   logic [CNT_W-1:0] w_pend_san;

`ifdef CLK_DIV_STEP_EN
   logic w_step_rise;

   step_edge_detect u_step_edge (
      .clk    (clk),
      .rst    (rst),
      .i_d    (bus.step_req),
      .o_rise (w_step_rise)
   );

   // Step mode freezes the counter; each detected request rise injects one tick.
   assign w_freeze = ~bus.run | bus.step_mode;
   assign w_step   = bus.step_mode & w_step_rise;
`else
   assign w_freeze = ~bus.run;
   assign w_step   = 1'b0;
`endif

   // r_div is always >= 1, so w_last never underflows. The counter cannot pass w_last because
   // a new divisor is only installed at a wrap, so equality is enough.
   assign w_last     = r_div - CNT_W'(1);
   assign w_wrap     = ~w_freeze & (r_cnt == w_last);
   assign w_pend_san = CNT_W'(div_sanitize(div_t'(r_pend)));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt  <= '0;
         r_div  <= RESET_DIV;
         r_pend <= '0;
         r_busy <= 1'b0;
         r_tick <= 1'b0;
         r_slow <= 1'b0;
      end else begin
         r_tick <= w_wrap | w_step;
         if (w_wrap | w_step) begin
            r_slow <= ~r_slow;
         end

         if (w_wrap) begin
            r_cnt <= '0;
         end else if (!w_freeze) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end

         if (w_wrap && r_busy) begin
            r_div  <= w_pend_san;
            r_busy <= 1'b0;
         end

         // Placed after the wrap apply: a load landing on the wrap cycle re-arms busy and
         // waits for the following wrap; a load while busy simply overwrites the pending value.
         if (bus.div_load) begin
            r_pend <= bus.div_val;
            r_busy <= 1'b1;
         end
      end
   end

   assign bus.cnt      = r_cnt;
   assign bus.tick     = r_tick;
   assign bus.slow_out = r_slow;
   assign bus.div_busy = r_busy;

endmodule

// File: tb/tb_clk_enable_divider.sv
// tb/tb_clk_enable_divider.sv - directed self-checking bench for clk_enable_divider (DEFAULT_DIV=4)

module tb_clk_enable_divider;

   localparam int CNT_W = 8;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   clk_enable_divider_if #(.CNT_W(CNT_W)) bus ();

   clk_enable_divider #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input int e_cnt, input logic e_tick,
                          input logic e_slow, input logic e_busy);
      chk({tag, ".cnt"},  32'(bus.cnt),      32'(e_cnt));
      chk({tag, ".tick"}, 32'(bus.tick),     32'(e_tick));
      chk({tag, ".slow"}, 32'(bus.slow_out), 32'(e_slow));
      chk({tag, ".busy"}, 32'(bus.div_busy), 32'(e_busy));
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b1;
      bus.run      = 1'b0;
      bus.div_load = 1'b0;
      bus.div_val  = '0;
`ifdef CLK_DIV_STEP_EN
      bus.step_mode = 1'b0;
      bus.step_req  = 1'b0;
`endif
      cyc(2);
      chk_out("reset", 0, 1'b0, 1'b0, 1'b0);

      // Basic counting, N=4: ticks in cycles 5, 9, 13.
      rst     = 1'b0;
      bus.run = 1'b1;
      for (int c = 1; c <= 13; c++) begin
         chk_out($sformatf("basic.c%0d", c), (c - 1) % 4,
                 (c == 5) || (c == 9) || (c == 13), 1'(((c - 1) / 4) % 2), 1'b0);
         if (c < 13) cyc();
      end

      // Load 2 at cnt=1: tick 3 cycles later, then every 2.
      cyc();                                         // c14 cnt=1
      bus.div_load = 1'b1;
      bus.div_val  = 8'd2;
      cyc(); bus.div_load = 1'b0;
      chk_out("load.c15", 2, 1'b0, 1'b1, 1'b1);
      cyc(); chk_out("load.c16", 3, 1'b0, 1'b1, 1'b1);
      cyc(); chk_out("load.c17", 0, 1'b1, 1'b0, 1'b0);
      cyc(); chk_out("load.c18", 1, 1'b0, 1'b0, 1'b0);
      cyc(); chk_out("load.c19", 0, 1'b1, 1'b1, 1'b0);
      cyc(); chk_out("load.c20", 1, 1'b0, 1'b1, 1'b0);
      cyc(); chk_out("load.c21", 0, 1'b1, 1'b0, 1'b0);

      // Back to N=4, then load 2 followed by 6 before the wrap: 6 wins.
      bus.div_load = 1'b1;
      bus.div_val  = 8'd4;
      cyc(); bus.div_load = 1'b0;
      chk_out("reload.c22", 1, 1'b0, 1'b0, 1'b1);
      cyc(); chk_out("reload.c23", 0, 1'b1, 1'b1, 1'b0);
      bus.div_load = 1'b1;
      bus.div_val  = 8'd2;
      cyc(); chk_out("dbl.c24", 1, 1'b0, 1'b1, 1'b1);
      bus.div_val  = 8'd6;
      cyc(); bus.div_load = 1'b0;
      cyc(); chk_out("dbl.c26", 3, 1'b0, 1'b1, 1'b1);
      cyc(); chk_out("dbl.c27", 0, 1'b1, 1'b0, 1'b0);
      cyc(5); chk_out("dbl.c32", 5, 1'b0, 1'b0, 1'b0);
      cyc(); chk_out("dbl.c33", 0, 1'b1, 1'b1, 1'b0);

      // Divisor 0: tick every cycle, slow_out toggles every cycle.
      bus.div_load = 1'b1;
      bus.div_val  = 8'd0;
      cyc(); bus.div_load = 1'b0;
      cyc(4); chk_out("div0.c38", 5, 1'b0, 1'b1, 1'b1);
      for (int k = 0; k < 4; k++) begin
         cyc();
         chk_out($sformatf("div0.c%0d", 39 + k), 0, 1'b1, 1'(k % 2), 1'b0);
      end

      // Divisor 1 loaded in a wrap cycle: applied at the following wrap.
      bus.div_load = 1'b1;
      bus.div_val  = 8'd1;
      cyc(); bus.div_load = 1'b0;
      chk_out("div1.c43", 0, 1'b1, 1'b0, 1'b1);
      cyc(); chk_out("div1.c44", 0, 1'b1, 1'b1, 1'b0);
      cyc(); chk_out("div1.c45", 0, 1'b1, 1'b0, 1'b0);

      // Return to N=4 and freeze at cnt=2 for 10 cycles with a load captured meanwhile.
      bus.div_load = 1'b1;
      bus.div_val  = 8'd4;
      cyc(); bus.div_load = 1'b0;
      chk_out("n4.c46", 0, 1'b1, 1'b1, 1'b1);
      cyc(); chk_out("n4.c47", 0, 1'b1, 1'b0, 1'b0);
      cyc(2); chk_out("n4.c49", 2, 1'b0, 1'b0, 1'b0);
      bus.run      = 1'b0;
      bus.div_load = 1'b1;
      bus.div_val  = 8'd3;
      for (int i = 0; i < 10; i++) begin
         cyc();
         bus.div_load = 1'b0;
         chk_out($sformatf("freeze.%0d", i), 2, 1'b0, 1'b0, 1'b1);
      end
      bus.run = 1'b1;
      cyc(); chk_out("resume.c60", 3, 1'b0, 1'b0, 1'b1);
      cyc(); chk_out("resume.c61", 0, 1'b1, 1'b1, 1'b0);
      cyc(3); chk_out("n3.c64", 0, 1'b1, 1'b0, 1'b0);

      // Reset at cnt=3 while a load of 7 is pending.
      bus.div_load = 1'b1;
      bus.div_val  = 8'd5;
      cyc(); bus.div_load = 1'b0;
      cyc(2); chk_out("n5.c67", 0, 1'b1, 1'b1, 1'b0);
      cyc(2);
      bus.div_load = 1'b1;
      bus.div_val  = 8'd7;
      cyc(); bus.div_load = 1'b0;
      chk_out("pre_rst.c70", 3, 1'b0, 1'b1, 1'b1);
      rst = 1'b1;
      cyc(); chk_out("rst.hold", 0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      for (int c = 1; c <= 9; c++) begin
         chk_out($sformatf("post_rst.c%0d", c), (c - 1) % 4,
                 (c == 5) || (c == 9), 1'(((c - 1) / 4) % 2), 1'b0);
         if (c < 9) cyc();
      end

`ifdef CLK_DIV_STEP_EN
      // Step mode: hold step_req for 5 cycles -> one tick 2 cycles after the rise.
      cyc(); chk_out("step.pre", 1, 1'b0, 1'b0, 1'b0);
      bus.step_mode = 1'b1;
      cyc(); chk_out("step.frozen", 1, 1'b0, 1'b0, 1'b0);
      bus.step_req = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         cyc();
         chk_out($sformatf("step.k%0d", k), 1, k == 2, k >= 2, 1'b0);
      end
      bus.step_req  = 1'b0;
      bus.step_mode = 1'b0;
      cyc(); chk_out("step.res1", 2, 1'b0, 1'b1, 1'b0);
      cyc(); chk_out("step.res2", 3, 1'b0, 1'b1, 1'b0);
      cyc(); chk_out("step.res3", 0, 1'b1, 1'b0, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
